// File: rtl/tile_line_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// tile_line_fetcher_pkg
//   Shared definitions for the tile line fetcher: tile geometry, pixel width,
//   the packed map-entry layout, the fetch FSM encoding and the map index
//   helper used to turn (line, column) into a tile map address.
// -----------------------------------------------------------------------------
package tile_line_fetcher_pkg;

  localparam int TILE_SIZE = 4;   // tiles are 4x4 pixels
  localparam int RGB_W     = 24;  // one pixel = {r, g, b} x 8 bits

  // One tile map entry: {tile_no[7:4], mirror[3:2], rotate[1:0]}
  typedef struct packed {
    logic [3:0] tile_no;
    logic [1:0] mirror;
    logic [1:0] rotate;
  } tile_attr_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAP_RD = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_BLANK  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Map address of the tile covering display line line_y at tile column col.
  function automatic logic [7:0] map_index(input logic [5:0] line_y,
                                           input logic [7:0] col,
                                           input int         map_w);
    return 8'((int'(line_y) / TILE_SIZE) * map_w + int'(col));
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// -----------------------------------------------------------------------------
// tile_map_ram
//   Tile map storage: DEPTH x DW, one synchronous write port and one
//   synchronous read-first read port (a read and write to the same address in
//   the same clock returns the old contents).
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset (read register only)
//   i_we, i_waddr,
//   i_wdata           write strobe, address, data
//   i_re, i_raddr     read enable and address; o_rdata holds until the next read
//   o_rdata           registered read data
// -----------------------------------------------------------------------------
module tile_map_ram #(
  parameter int DEPTH = 192,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: storage arrays carry no reset so they can map onto RAM macros;
  // only the read-data register is reset.
  always_ff @(posedge i_clk) begin
    if (i_we && (int'(i_waddr) < DEPTH)) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // The read register holds between reads, so the attributes fetched for one
  // tile stay stable while its four pixels are requested.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/tile_line_fetcher.sv
// -----------------------------------------------------------------------------
// tile_line_fetcher
//   Fills one display line at a time into the back half of a ping-pong line
//   buffer by walking the tile map, requesting each pixel from tile_data and
//   storing the returned RGB. Buffers swap when the line is complete; the
//   display side reads only the front half with a 1-clock registered read.
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_map_we/addr/data           tile map write port (game logic)
//   i_line_start, i_line_y       start filling line i_line_y
//   o_busy, o_line_ready         fill in progress / fill done + swap pulse
//   o_overrun, o_fetch_err       start dropped while busy / pixel timed out
//   o_tile_no/x/y/mirror/rotate,
//   o_read                       pixel request to tile_data
//   i_rgb_data, i_valid          pixel response from tile_data
//   i_pixel_x, o_pixel_rgb       front-buffer read column and pixel
// -----------------------------------------------------------------------------
module tile_line_fetcher
  import tile_line_fetcher_pkg::*;
#(
  parameter int MAP_W   = 16,
  parameter int MAP_H   = 12,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_map_we,
  input  logic [7:0]       i_map_addr,
  input  logic [7:0]       i_map_data,
  input  logic             i_line_start,
  input  logic [5:0]       i_line_y,
  output logic             o_busy,
  output logic             o_line_ready,
  output logic             o_overrun,
  output logic             o_fetch_err,
  output logic [3:0]       o_tile_no,
  output logic [1:0]       o_tile_x,
  output logic [1:0]       o_tile_y,
  output logic [1:0]       o_mirror,
  output logic [1:0]       o_rotate,
  output logic             o_read,
  input  logic [RGB_W-1:0] i_rgb_data,
  input  logic             i_valid,
  input  logic [5:0]       i_pixel_x,
  output logic [RGB_W-1:0] o_pixel_rgb
);

  localparam int LINE_W = MAP_W * TILE_SIZE;
  localparam int LINES  = MAP_H * TILE_SIZE;
  localparam int XW     = $clog2(LINE_W);
  localparam int CW     = $clog2(MAP_W);
  localparam int TW     = $clog2(TIMEOUT + 1);

  localparam logic [6:0]    LINES_C  = 7'(LINES);
  localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [5:0]    y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    px_q, px_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          sel_q, sel_d;     // back-buffer half; front is ~sel_q
  logic [RGB_W-1:0] pixel_q;

  logic [7:0]    map_rdata;
  logic          map_re;
  tile_attr_t    attr;
  logic          tmo_hit, pix_done, last_px;
  logic          wr_en;
  logic [XW:0]   wr_addr;
  logic [RGB_W-1:0] wr_data;

  // ---------------------------------------------------------------------------
  // Tile map
  // ---------------------------------------------------------------------------
  tile_map_ram #(
    .DEPTH (MAP_W * MAP_H),
    .AW    (8),
    .DW    (8)
  ) u_map (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_map_we),
    .i_waddr (i_map_addr),
    .i_wdata (i_map_data),
    .i_re    (map_re),
    .i_raddr (map_index(y_q, 8'(col_q), MAP_W)),
    .o_rdata (map_rdata)
  );

  assign attr      = tile_attr_t'(map_rdata);
  assign o_tile_no = attr.tile_no;
  assign o_mirror  = attr.mirror;
  assign o_rotate  = attr.rotate;
  assign o_tile_x  = px_q;
  assign o_tile_y  = y_q[1:0];

  // A pixel finishes on a response, or on the last allowed WAIT clock without one.
  assign tmo_hit  = (state_q == S_WAIT) && !i_valid && (tmo_q == TMO_LAST);
  assign pix_done = i_valid || tmo_hit;
  assign last_px  = (px_q == 2'd3) && (col_q == COL_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      y_q   <= '0;
      col_q <= '0;
      px_q  <= '0;
      tmo_q <= '0;
      sel_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      col_q <= col_d;
      px_q  <= px_d;
      tmo_q <= tmo_d;
      sel_q <= sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    col_d   = col_q;
    px_d    = px_q;
    tmo_d   = tmo_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_line_start) begin
          y_d     = i_line_y;
          col_d   = '0;
          px_d    = '0;
          // Lines below the map never touch tile_data; they are blanked.
          state_d = ({1'b0, i_line_y} < LINES_C) ? S_MAP_RD : S_BLANK;
        end
      end
      S_MAP_RD: state_d = S_REQ;
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pix_done) begin
          // {col, px} is the pixel column within the line; stepping it walks
          // px 0..3 then moves to the next tile column.
          {col_d, px_d} = {col_q, px_q} + 1'b1;
          if (last_px)              state_d = S_DONE;
          else if (px_q == 2'd3)    state_d = S_MAP_RD;
          else                      state_d = S_REQ;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_BLANK: begin
        {col_d, px_d} = {col_q, px_q} + 1'b1;
        if (last_px) state_d = S_DONE;
      end
      S_DONE: begin
        sel_d   = ~sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy       = 1'b0;
    o_read       = 1'b0;
    o_line_ready = 1'b0;
    o_fetch_err  = 1'b0;
    map_re       = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      S_MAP_RD: begin
        o_busy = 1'b1;
        map_re = 1'b1;
      end
      S_REQ: begin
        o_busy = 1'b1;
        o_read = 1'b1;
      end
      S_WAIT: begin
        o_busy      = 1'b1;
        o_fetch_err = tmo_hit;
        wr_en       = pix_done;
      end
      S_BLANK: begin
        o_busy = 1'b1;
        wr_en  = 1'b1;
      end
      S_DONE:  o_line_ready = 1'b1;
      default: ;
    endcase
  end

  assign o_overrun = i_line_start && o_busy;

  // ---------------------------------------------------------------------------
  // Ping-pong line buffer: back half written by the fill, front half read by
  // the display, so the display never observes a partially filled line.
  // ---------------------------------------------------------------------------
  logic [RGB_W-1:0] line_buf_q [2*LINE_W];

  assign wr_addr = {sel_q, col_q, px_q};
  assign wr_data = ((state_q == S_WAIT) && i_valid) ? i_rgb_data : '0;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      line_buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pixel_q <= '0;
    end else begin
      pixel_q <= line_buf_q[{~sel_q, i_pixel_x[XW-1:0]}];
    end
  end

  assign o_pixel_rgb = pixel_q;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// -----------------------------------------------------------------------------
// tb_tile_line_fetcher
//   Scoreboard bench. A small tile_data stand-in answers each o_read one clock
//   later with a pixel derived from the request fields. Starting a fill pushes
//   the expected request sequence and the expected o_line_ready cycle; a
//   monitor pops and compares whenever the DUT issues o_read or o_line_ready.
//   Filled lines are then read back through the front-buffer port.
// -----------------------------------------------------------------------------
module tb_tile_line_fetcher;

  typedef struct packed {
    logic [3:0] tile;
    logic [1:0] mir;
    logic [1:0] rot;
    logic [1:0] x;
    logic [1:0] y;
  } req_t;

  logic        i_clk;
  logic        i_rst;
  logic        i_map_we;
  logic [7:0]  i_map_addr;
  logic [7:0]  i_map_data;
  logic        i_line_start;
  logic [5:0]  i_line_y;
  logic        o_busy, o_line_ready, o_overrun, o_fetch_err;
  logic [3:0]  o_tile_no;
  logic [1:0]  o_tile_x, o_tile_y, o_mirror, o_rotate;
  logic        o_read;
  logic [23:0] i_rgb_data = 24'h0;
  logic        i_valid = 1'b0;
  logic [5:0]  i_pixel_x;
  logic [23:0] o_pixel_rgb;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   err_cnt  = 0;
  int   err_last = 0;
  int   gap_bad  = 0;
  bit   stub_en  = 1'b1;

  req_t        req_q [$];
  int          rdy_q [$];
  logic [7:0]  map_m [256];
  logic [23:0] exp_next  [64];
  logic [23:0] exp_front [64];

  tile_line_fetcher dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_map_we     (i_map_we),
    .i_map_addr   (i_map_addr),
    .i_map_data   (i_map_data),
    .i_line_start (i_line_start),
    .i_line_y     (i_line_y),
    .o_busy       (o_busy),
    .o_line_ready (o_line_ready),
    .o_overrun    (o_overrun),
    .o_fetch_err  (o_fetch_err),
    .o_tile_no    (o_tile_no),
    .o_tile_x     (o_tile_x),
    .o_tile_y     (o_tile_y),
    .o_mirror     (o_mirror),
    .o_rotate     (o_rotate),
    .o_read       (o_read),
    .i_rgb_data   (i_rgb_data),
    .i_valid      (i_valid),
    .i_pixel_x    (i_pixel_x),
    .o_pixel_rgb  (o_pixel_rgb)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Pixel produced by the tile_data stand-in for one request.
  function automatic logic [23:0] pix_model(input logic [3:0] t, input logic [1:0] m,
                                            input logic [1:0] r, input logic [1:0] x,
                                            input logic [1:0] y);
    return {t, m, r, 4'h5, x, y, t ^ {x, y}, ~t};
  endfunction

  // tile_data stand-in with one clock of latency.
  always @(posedge i_clk) begin
    if (stub_en && o_read) begin
      i_valid    <= 1'b1;
      i_rgb_data <= pix_model(o_tile_no, o_mirror, o_rotate, o_tile_x, o_tile_y);
    end else begin
      i_valid    <= 1'b0;
      i_rgb_data <= 24'hBAD0BA;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each DUT request / completion with the scoreboard.
  always @(negedge i_clk) begin : monitor
    req_t exp_req;
    int   exp_cyc;
    if (!i_rst) begin
      if (o_read) begin
        if (req_q.size() == 0) begin
          check("unexpected_read", 32'd1, 32'd0);
        end else begin
          exp_req = req_q.pop_front();
          check("read_request", 32'({o_tile_no, o_mirror, o_rotate, o_tile_x, o_tile_y}),
                32'(exp_req));
        end
      end
      if (o_line_ready) begin
        if (rdy_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_cyc = rdy_q.pop_front();
          check("ready_cycle", 32'(cyc), 32'(exp_cyc));
        end
      end
      if (o_fetch_err) begin
        if (err_cnt > 0 && !((cyc - err_last) == 16 || (cyc - err_last) == 17)) gap_bad++;
        err_cnt++;
        err_last = cyc;
      end
    end
  end

  task automatic map_wr(input int a, input logic [7:0] d);
    @(negedge i_clk);
    i_map_we   = 1'b1;
    i_map_addr = 8'(a);
    i_map_data = d;
    map_m[a]   = d;
    @(negedge i_clk);
    i_map_we   = 1'b0;
  endtask

  // Builds the expected requests / line / ready cycle, then pulses i_line_start.
  task automatic start_fill(input logic [5:0] y, input bit resp);
    req_t       r;
    logic [7:0] e;
    int         lat;
    if (y < 6'd48) begin
      for (int c = 0; c < 16; c++) begin
        e = map_m[(int'(y) / 4) * 16 + c];
        for (int p = 0; p < 4; p++) begin
          r.tile = e[7:4];
          r.mir  = e[3:2];
          r.rot  = e[1:0];
          r.x    = 2'(p);
          r.y    = y[1:0];
          req_q.push_back(r);
          exp_next[c*4+p] = resp ? pix_model(r.tile, r.mir, r.rot, r.x, r.y) : 24'h0;
        end
      end
      lat = resp ? 145 : 1041;
    end else begin
      for (int i = 0; i < 64; i++) exp_next[i] = 24'h0;
      lat = 65;
    end
    @(negedge i_clk);
    i_line_start = 1'b1;
    i_line_y     = y;
    rdy_q.push_back(cyc + lat);
    @(negedge i_clk);
    i_line_start = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while ((rdy_q.size() != 0 || o_busy) && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    check("fill_finished", 32'(rdy_q.size()), 32'd0);
    exp_front = exp_next;
    @(negedge i_clk);
  endtask

  task automatic check_line(input string name);
    for (int x = 0; x < 64; x++) begin
      @(negedge i_clk);
      i_pixel_x = 6'(x);
      @(negedge i_clk);
      check(name, 32'(o_pixel_rgb), 32'(exp_front[x]));
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    i_rst        = 1'b1;
    i_map_we     = 1'b0;
    i_map_addr   = '0;
    i_map_data   = '0;
    i_line_start = 1'b0;
    i_line_y     = '0;
    i_pixel_x    = '0;
    repeat (3) @(negedge i_clk);
    check("rst_outputs", 32'({o_busy, o_read, o_line_ready, o_overrun, o_fetch_err,
                              o_tile_no, o_tile_x, o_tile_y, o_mirror, o_rotate}), 32'd0);
    check("rst_pixel", 32'(o_pixel_rgb), 32'd0);
    i_rst = 1'b0;

    // Map rows 0 and 1; entry 0 is tile 6 with no mirror/rotate.
    map_wr(0, 8'h60);
    for (int c = 1; c < 16; c++) map_wr(c, 8'(c * 16 + c * 5));
    for (int c = 0; c < 16; c++) map_wr(16 + c, 8'(8'hA3 + c * 37));

    // 1: line 1 -> tile 6 row 1 requests, ready at clock 145.
    start_fill(6'd1, 1'b1);
    wait_ready(400);
    check_line("t1_line1");

    // 2: line 0 then line 5; front must hold line 0 while line 5 fills.
    start_fill(6'd0, 1'b1);
    wait_ready(400);
    check_line("t2_line0");
    start_fill(6'd5, 1'b1);
    for (int k = 0; k < 20; k++) begin
      i_pixel_x = 6'(k * 3);
      @(negedge i_clk);
      @(negedge i_clk);
      check("t2_front_stable", 32'(o_pixel_rgb), 32'(exp_front[k*3]));
    end
    wait_ready(400);
    check_line("t2_line5");

    // 3: start request at clock 20 of a fill is dropped with an overrun pulse.
    start_fill(6'd2, 1'b1);
    repeat (18) @(negedge i_clk);
    i_line_start = 1'b1;
    i_line_y     = 6'd7;
    #1 check("t3_overrun", 32'(o_overrun), 32'd1);
    @(negedge i_clk);
    i_line_start = 1'b0;
    #1 check("t3_overrun_pulse", 32'(o_overrun), 32'd0);
    wait_ready(400);
    repeat (200) @(negedge i_clk);
    check("t3_no_second_fill", 32'({o_busy, 8'(req_q.size())}), 32'd0);
    check_line("t3_line2");

    // 4: no responses -> one fetch error per pixel, black line, ready at 1041.
    stub_en = 1'b0;
    err_cnt = 0;
    gap_bad = 0;
    start_fill(6'd3, 1'b0);
    wait_ready(1500);
    check("t4_err_count", 32'(err_cnt), 32'd64);
    check("t4_err_gap", 32'(gap_bad), 32'd0);
    check_line("t4_black");
    stub_en = 1'b1;

    // 5: reset mid-fill clears outputs at once; the next fill completes.
    start_fill(6'd4, 1'b1);
    repeat (30) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 check("t5_rst_outputs", 32'({o_busy, o_read, o_line_ready, o_overrun, o_fetch_err,
                                    o_tile_no, o_tile_x, o_tile_y, o_mirror, o_rotate}), 32'd0);
    check("t5_rst_pixel", 32'(o_pixel_rgb), 32'd0);
    req_q.delete();
    rdy_q.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    start_fill(6'd6, 1'b1);
    wait_ready(400);
    check_line("t5_line6");

    // 6: line below the map -> no requests, black line, ready after 65 clocks.
    start_fill(6'd48, 1'b1);
    wait_ready(200);
    check_line("t6_black");
    check("t6_no_reads", 32'(req_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
